// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU_System hardwired controller.
// Holds the FSM state enum, opcode map, FunSel / ALU / mux / register-select
// constants, the control-word payload and small select helpers.
package alu_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned FS_W    = 2;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned RSEL_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_FETCH_L = 3'd2,
        ST_FETCH_H = 3'd3,
        ST_EXEC1   = 3'd4,
        ST_EXEC2   = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    // Opcodes (IR[15:12])
    localparam logic [OP_W-1:0] OP_LDI = 4'h0;
    localparam logic [OP_W-1:0] OP_LD  = 4'h1;
    localparam logic [OP_W-1:0] OP_ST  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB = 4'h4;
    localparam logic [OP_W-1:0] OP_AND = 4'h5;
    localparam logic [OP_W-1:0] OP_OR  = 4'h6;
    localparam logic [OP_W-1:0] OP_INC = 4'h7;
    localparam logic [OP_W-1:0] OP_BRA = 4'h8;
    localparam logic [OP_W-1:0] OP_BNE = 4'h9;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    // Register-file / ARF / IR function selects
    localparam logic [FS_W-1:0] FS_CLEAR = 2'b00;
    localparam logic [FS_W-1:0] FS_LOAD  = 2'b01;
    localparam logic [FS_W-1:0] FS_INC   = 2'b10;

    // ALU function selects
    localparam logic [ALU_W-1:0] ALU_PASS_A = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_ADD    = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SUB    = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_AND    = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_OR     = 4'b1000;

    // Mux selects
    localparam logic [1:0] MUXA_ALU = 2'd0;
    localparam logic [1:0] MUXA_MEM = 2'd1;
    localparam logic [1:0] MUXA_IR  = 2'd2;
    localparam logic [1:0] MUXB_IR  = 2'd2;
    localparam logic       MUXC_RF  = 1'b0;

    // ARF / RF selects
    localparam logic [1:0]        ARF_SEL_PC  = 2'b11;
    localparam logic [1:0]        ARF_SEL_AR  = 2'b10;
    localparam logic [RSEL_W-1:0] ARF_RSEL_PC = 4'b0001;
    localparam logic [RSEL_W-1:0] ARF_RSEL_AR = 4'b0010;
    localparam logic [RSEL_W-1:0] RF_RSEL_ALL = 4'b1111;

    typedef struct packed {
        logic [1:0]        mux_a_sel;
        logic [1:0]        mux_b_sel;
        logic              mux_c_sel;
        logic [2:0]        rf_out_a_sel;
        logic [2:0]        rf_out_b_sel;
        logic [FS_W-1:0]   rf_fun_sel;
        logic [RSEL_W-1:0] rf_t_sel;
        logic [RSEL_W-1:0] rf_r_sel;
        logic [ALU_W-1:0]  alu_fun_sel;
        logic [1:0]        arf_out_a_sel;
        logic [1:0]        arf_out_b_sel;
        logic [FS_W-1:0]   arf_fun_sel;
        logic [RSEL_W-1:0] arf_r_sel;
        logic [FS_W-1:0]   ir_fun_sel;
        logic              ir_enable;
        logic              ir_lh;
        logic              mem_wr;
        logic              mem_cs;
    } ctrl_word_t;

    // Rn -> RF output select 3'b1nn
    function automatic logic [2:0] rf_out_sel(input logic [1:0] n);
        return {1'b1, n};
    endfunction

    // Rn -> RF write-enable one-hot 4'b1000 >> n
    function automatic logic [RSEL_W-1:0] rf_r_sel(input logic [1:0] n);
        return 4'b1000 >> n;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational control-word decoder for the ALU_System controller.
// Ports: state (FSM state), ir_high (IR[15:8]), zero_flag (registered Z),
//        ctrl (full datapath control word; idle word unless overridden).
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [7:0] ir_high,
    input  logic       zero_flag,
    output ctrl_word_t ctrl
);

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;

    assign op = ir_high[7:4];
    assign rd = ir_high[3:2];
    assign rs = ir_high[1:0];

    // Control word per state/opcode; memory chip select is active low
    always_comb begin
        ctrl        = '0;
        ctrl.mem_cs = 1'b1;
        case (state)
            ST_INIT: begin
                ctrl.arf_r_sel   = ARF_RSEL_PC | ARF_RSEL_AR;
                ctrl.arf_fun_sel = FS_CLEAR;
                ctrl.rf_r_sel    = RF_RSEL_ALL;
                ctrl.rf_fun_sel  = FS_CLEAR;
            end
            ST_FETCH_L, ST_FETCH_H: begin
                ctrl.arf_out_b_sel = ARF_SEL_PC;
                ctrl.mem_cs        = 1'b0;
                ctrl.ir_enable     = 1'b1;
                ctrl.ir_lh         = (state == ST_FETCH_H);
                ctrl.ir_fun_sel    = FS_LOAD;
                ctrl.arf_r_sel     = ARF_RSEL_PC;
                ctrl.arf_fun_sel   = FS_INC;
            end
            ST_EXEC1: begin
                case (op)
                    OP_LDI: begin
                        ctrl.mux_a_sel  = MUXA_IR;
                        ctrl.rf_r_sel   = rf_r_sel(rd);
                        ctrl.rf_fun_sel = FS_LOAD;
                    end
                    OP_LD, OP_ST: begin
                        ctrl.mux_b_sel   = MUXB_IR;
                        ctrl.arf_r_sel   = ARF_RSEL_AR;
                        ctrl.arf_fun_sel = FS_LOAD;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl.mux_c_sel    = MUXC_RF;
                        ctrl.rf_out_a_sel = rf_out_sel(rd);
                        ctrl.rf_out_b_sel = rf_out_sel(rs);
                        case (op)
                            OP_ADD:  ctrl.alu_fun_sel = ALU_ADD;
                            OP_SUB:  ctrl.alu_fun_sel = ALU_SUB;
                            OP_AND:  ctrl.alu_fun_sel = ALU_AND;
                            default: ctrl.alu_fun_sel = ALU_OR;
                        endcase
                        ctrl.mux_a_sel  = MUXA_ALU;
                        ctrl.rf_r_sel   = rf_r_sel(rd);
                        ctrl.rf_fun_sel = FS_LOAD;
                    end
                    OP_INC: begin
                        ctrl.rf_r_sel   = rf_r_sel(rd);
                        ctrl.rf_fun_sel = FS_INC;
                    end
                    OP_BRA: begin
                        ctrl.mux_b_sel   = MUXB_IR;
                        ctrl.arf_r_sel   = ARF_RSEL_PC;
                        ctrl.arf_fun_sel = FS_LOAD;
                    end
                    OP_BNE: begin
                        // Branch taken only when the last ALU result was non-zero
                        if (!zero_flag) begin
                            ctrl.mux_b_sel   = MUXB_IR;
                            ctrl.arf_r_sel   = ARF_RSEL_PC;
                            ctrl.arf_fun_sel = FS_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                case (op)
                    OP_LD: begin
                        ctrl.arf_out_b_sel = ARF_SEL_AR;
                        ctrl.mem_cs        = 1'b0;
                        ctrl.mux_a_sel     = MUXA_MEM;
                        ctrl.rf_r_sel      = rf_r_sel(rd);
                        ctrl.rf_fun_sel    = FS_LOAD;
                    end
                    OP_ST: begin
                        ctrl.arf_out_b_sel = ARF_SEL_AR;
                        ctrl.rf_out_a_sel  = rf_out_sel(rs);
                        ctrl.mux_c_sel     = MUXC_RF;
                        ctrl.alu_fun_sel   = ALU_PASS_A;
                        ctrl.mem_cs        = 1'b0;
                        ctrl.mem_wr        = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_system_ctrl.sv
// Hardwired fetch/decode/execute controller for the ALU_System datapath.
// Inputs : Clock, Reset_n (async, active low), Start, IR_High (IR[15:8]),
//          ALU_ZCNO (registered {Z,C,N,O}).
// Outputs: every ALU_System select/enable (combinational from state/IR),
//          Halted (in HALT), Illegal (registered pulse), Retired (counter).
module alu_system_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned RET_W = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [7:0]       IR_High,
    input  logic [3:0]       ALU_ZCNO,
    output logic [1:0]       MuxASel,
    output logic [1:0]       MuxBSel,
    output logic             MuxCSel,
    output logic [2:0]       RF_OutASel,
    output logic [2:0]       RF_OutBSel,
    output logic [1:0]       RF_FunSel,
    output logic [3:0]       RF_TSel,
    output logic [3:0]       RF_RSel,
    output logic [3:0]       ALU_FunSel,
    output logic [1:0]       ARF_OutASel,
    output logic [1:0]       ARF_OutBSel,
    output logic [1:0]       ARF_FunSel,
    output logic [3:0]       ARF_RSel,
    output logic [1:0]       IR_Funsel,
    output logic             IR_Enable,
    output logic             IR_LH,
    output logic             Mem_WR,
    output logic             Mem_CS,
    output logic             Halted,
    output logic             Illegal,
    output logic [RET_W-1:0] Retired
);

    state_t           state;
    state_t           state_next;
    logic             done_c;
    logic             illegal_c;
    logic [3:0]       op;
    logic [RET_W-1:0] retired_q;
    logic             illegal_q;
    ctrl_word_t       ctrl;
    logic             unused_flags;

    assign op           = IR_High[7:4];
    assign unused_flags = ^ALU_ZCNO[2:0];

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next state plus retire/illegal strobes
    always_comb begin
        state_next = state;
        done_c     = 1'b0;
        illegal_c  = 1'b0;
        case (state)
            ST_IDLE:    if (Start) state_next = ST_INIT;
            ST_INIT:    state_next = ST_FETCH_L;
            ST_FETCH_L: state_next = ST_FETCH_H;
            ST_FETCH_H: state_next = ST_EXEC1;
            ST_EXEC1: begin
                case (op)
                    OP_LD, OP_ST: state_next = ST_EXEC2;
                    OP_HLT:       state_next = ST_HALT;
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_INC, OP_BRA, OP_BNE: begin
                        state_next = ST_FETCH_L;
                        done_c     = 1'b1;
                    end
                    default: begin
                        // Undefined opcode retires as a NOP
                        state_next = ST_FETCH_L;
                        done_c     = 1'b1;
                        illegal_c  = 1'b1;
                    end
                endcase
            end
            ST_EXEC2: begin
                state_next = ST_FETCH_L;
                done_c     = 1'b1;
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Retired counter (wraps) and one-cycle Illegal pulse
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (done_c) retired_q <= retired_q + RET_W'(1);
            illegal_q <= illegal_c;
        end
    end

    alu_ctrl_decode u_decode (
        .state     (state),
        .ir_high   (IR_High),
        .zero_flag (ALU_ZCNO[3]),
        .ctrl      (ctrl)
    );

    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign RF_OutASel  = ctrl.rf_out_a_sel;
    assign RF_OutBSel  = ctrl.rf_out_b_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_TSel     = ctrl.rf_t_sel;
    assign RF_RSel     = ctrl.rf_r_sel;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ARF_OutASel = ctrl.arf_out_a_sel;
    assign ARF_OutBSel = ctrl.arf_out_b_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign ARF_RSel    = ctrl.arf_r_sel;
    assign IR_Funsel   = ctrl.ir_fun_sel;
    assign IR_Enable   = ctrl.ir_enable;
    assign IR_LH       = ctrl.ir_lh;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign Halted      = (state == ST_HALT);
    assign Illegal     = illegal_q;
    assign Retired     = retired_q;

endmodule

// File: tb/tb_alu_system_ctrl.sv
// Bench for alu_system_ctrl: a small behavioural ALU_System datapath driven by
// the controller runs directed programs; expected end-state values are queued
// when each program is loaded and compared once the machine halts.
module tb_alu_system_ctrl;

    logic       Clock   = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start   = 1'b0;
    logic [7:0] IR_High;
    logic [3:0] ALU_ZCNO;
    logic [1:0] MuxASel, MuxBSel;
    logic       MuxCSel;
    logic [2:0] RF_OutASel, RF_OutBSel;
    logic [1:0] RF_FunSel;
    logic [3:0] RF_TSel, RF_RSel, ALU_FunSel;
    logic [1:0] ARF_OutASel, ARF_OutBSel, ARF_FunSel;
    logic [3:0] ARF_RSel;
    logic [1:0] IR_Funsel;
    logic       IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted, Illegal;
    logic [7:0] Retired;

    alu_system_ctrl #(.RET_W(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start),
        .IR_High(IR_High), .ALU_ZCNO(ALU_ZCNO),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
        .RF_FunSel(RF_FunSel), .RF_TSel(RF_TSel), .RF_RSel(RF_RSel),
        .ALU_FunSel(ALU_FunSel),
        .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RSel(ARF_RSel),
        .IR_Funsel(IR_Funsel), .IR_Enable(IR_Enable), .IR_LH(IR_LH),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .Halted(Halted), .Illegal(Illegal), .Retired(Retired)
    );

    always #5 Clock = ~Clock;

    // ---------------- behavioural datapath ----------------
    logic [7:0]  prog [256];
    logic [7:0]  mem  [256];
    logic [7:0]  rf   [4];
    logic [7:0]  pc, ar;
    logic [15:0] ir;
    logic [3:0]  flags;
    logic        load_req = 1'b0;

    logic [7:0] rf_a, rf_b, arf_a, arf_b, alu_a, alu_y, mdata, mux_a, mux_b;

    assign IR_High  = ir[15:8];
    assign ALU_ZCNO = flags;

    function automatic logic [7:0] arf_pick(input logic [1:0] sel, input logic [7:0] p,
                                            input logic [7:0] a);
        if (sel == 2'b11) return p;
        if (sel == 2'b10) return a;
        return 8'h00;
    endfunction

    function automatic logic [7:0] fs_apply(input logic [7:0] cur, input logic [1:0] fs,
                                            input logic [7:0] d);
        case (fs)
            2'b00:   return 8'h00;
            2'b01:   return d;
            2'b10:   return cur + 8'h01;
            default: return cur - 8'h01;
        endcase
    endfunction

    always_comb begin
        rf_a  = RF_OutASel[2] ? rf[RF_OutASel[1:0]] : 8'h00;
        rf_b  = RF_OutBSel[2] ? rf[RF_OutBSel[1:0]] : 8'h00;
        arf_a = arf_pick(ARF_OutASel, pc, ar);
        arf_b = arf_pick(ARF_OutBSel, pc, ar);
        alu_a = MuxCSel ? arf_a : rf_a;
        case (ALU_FunSel)
            4'b0100: alu_y = alu_a + rf_b;
            4'b0101: alu_y = alu_a - rf_b;
            4'b0111: alu_y = alu_a & rf_b;
            4'b1000: alu_y = alu_a | rf_b;
            default: alu_y = alu_a;
        endcase
        mdata = mem[arf_b];
        case (MuxASel)
            2'd0:    mux_a = alu_y;
            2'd1:    mux_a = mdata;
            2'd2:    mux_a = ir[7:0];
            default: mux_a = arf_a;
        endcase
        case (MuxBSel)
            2'd1:    mux_b = mdata;
            2'd2:    mux_b = ir[7:0];
            default: mux_b = alu_y;
        endcase
    end

    always @(posedge Clock) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
            for (int n = 0; n < 4; n++) rf[n] <= 8'h00;
            pc    <= 8'h00;
            ar    <= 8'h00;
            ir    <= 16'h0000;
            flags <= 4'h0;
        end else begin
            if (!Mem_CS && Mem_WR) mem[arf_b] <= alu_y;
            if (IR_Enable && IR_Funsel == 2'b01) begin
                if (IR_LH) ir[15:8] <= mdata;
                else       ir[7:0]  <= mdata;
            end
            for (int n = 0; n < 4; n++)
                if (RF_RSel[3-n]) rf[n] <= fs_apply(rf[n], RF_FunSel, mux_a);
            if (ARF_RSel[0]) pc <= fs_apply(pc, ARF_FunSel, mux_b);
            if (ARF_RSel[1]) ar <= fs_apply(ar, ARF_FunSel, mux_b);
            if (RF_RSel != 4'h0 && RF_FunSel == 2'b01 && MuxASel == 2'd0)
                flags <= {alu_y == 8'h00, 1'b0, alu_y[7], 1'b0};
        end
    end

    // ---------------- output monitors ----------------
    logic       mon_clr = 1'b1;
    int         wr_cycles, ill_cycles, ill_viol, lat;
    logic [7:0] prev_ret;
    int         lat_q[$];

    always @(negedge Clock) begin
        if (mon_clr) begin
            wr_cycles = 0; ill_cycles = 0; ill_viol = 0; lat = 0; prev_ret = 8'h00;
            lat_q.delete();
        end else begin
            // Cycles from FETCH_L to the retiring edge of each instruction
            if (Retired != prev_ret) begin
                lat_q.push_back(lat);
                prev_ret = Retired;
            end
            if (IR_Enable && !IR_LH) lat = 1;
            else                     lat++;
            if (!Mem_CS && Mem_WR) wr_cycles++;
            if (Illegal) ill_cycles++;
            if (IR_High[7:4] == 4'hC && !IR_Enable && !Halted &&
                (RF_RSel != 4'h0 || ARF_RSel != 4'h0 || !Mem_CS || Mem_WR))
                ill_viol++;
        end
    end

    // ---------------- scoreboard and checks ----------------
    typedef struct {
        string tag;
        int    kind;
        int    idx;
        int    expv;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_RET = 3, K_HALT = 4,
                   K_WR = 5, K_LAT = 6, K_ILL = 7, K_VIOL = 8;

    function automatic int observe(input int kind, input int idx);
        case (kind)
            K_REG:   return int'(rf[idx]);
            K_MEM:   return int'(mem[idx]);
            K_PC:    return int'(pc);
            K_RET:   return int'(Retired);
            K_HALT:  return int'(Halted);
            K_WR:    return wr_cycles;
            K_LAT:   return (lat_q.size() > idx) ? lat_q[idx] : -1;
            K_ILL:   return ill_cycles;
            default: return ill_viol;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic push_exp(input string tag, input int kind, input int idx, input int expv);
        exp_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.expv = expv;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind, e.idx), e.expv);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    // Instruction word: low byte (immediate/address) first, then IR[15:8]
    task automatic put(input int addr, input logic [7:0] lo, input logic [7:0] hi);
        prog[addr]     = lo;
        prog[addr + 1] = hi;
    endtask

    // Reset, load program image, start, and run until HALT (bounded)
    task automatic run_program(input string name, input int max_cycles);
        Reset_n  = 1'b0;
        Start    = 1'b0;
        load_req = 1'b1;
        mon_clr  = 1'b1;
        @(posedge Clock);
        #1 load_req = 1'b0;
        @(negedge Clock);
        #1 mon_clr = 1'b0;
        Reset_n = 1'b1;
        Start   = 1'b1;
        for (int c = 0; c < max_cycles && !Halted; c++) @(negedge Clock);
        check({name, "_halt_reached"}, int'(Halted), 1);
        drain();
    endtask

    initial begin
        #1;
        // Reset state: idle outputs
        check("rst_mem_cs", int'(Mem_CS), 1);
        check("rst_ir_en", int'(IR_Enable), 0);
        check("rst_halted", int'(Halted), 0);
        check("rst_retired", int'(Retired), 0);
        check("rst_rsel", int'({RF_RSel, ARF_RSel}), 0);

        // LDI R1,0x05 ; HLT
        clear_prog();
        put(8'h00, 8'h05, 8'h04);
        put(8'h02, 8'h00, 8'hF0);
        push_exp("a_r1", K_REG, 1, 8'h05);
        push_exp("a_pc", K_PC, 0, 8'h04);
        push_exp("a_retired", K_RET, 0, 1);
        push_exp("a_lat_ldi", K_LAT, 0, 3);
        run_program("a", 200);

        // LDI R1,3 ; LDI R2,4 ; ADD R1,R2 ; ST [0x40],R1 ; HLT
        clear_prog();
        put(8'h00, 8'h03, 8'h04);
        put(8'h02, 8'h04, 8'h08);
        put(8'h04, 8'h00, 8'h36);
        put(8'h06, 8'h40, 8'h21);
        put(8'h08, 8'h00, 8'hF0);
        push_exp("b_mem40", K_MEM, 8'h40, 8'h07);
        push_exp("b_r1", K_REG, 1, 8'h07);
        push_exp("b_wr_cycles", K_WR, 0, 1);
        push_exp("b_retired", K_RET, 0, 4);
        push_exp("b_lat_add", K_LAT, 2, 3);
        push_exp("b_lat_st", K_LAT, 3, 4);
        run_program("b", 300);

        // LD R3,[0x40] with mem[0x40] = 0xA5 ; HLT
        clear_prog();
        put(8'h00, 8'h40, 8'h1C);
        put(8'h02, 8'h00, 8'hF0);
        prog[8'h40] = 8'hA5;
        push_exp("c_r3", K_REG, 3, 8'hA5);
        push_exp("c_lat_ld", K_LAT, 0, 4);
        push_exp("c_retired", K_RET, 0, 1);
        push_exp("c_wr_cycles", K_WR, 0, 0);
        run_program("c", 200);

        // SUB R1,R1 -> Z=1, BNE not taken
        clear_prog();
        put(8'h00, 8'h03, 8'h04);
        put(8'h02, 8'h00, 8'h45);
        put(8'h04, 8'h20, 8'h90);
        put(8'h06, 8'h11, 8'h08);
        put(8'h08, 8'h00, 8'hF0);
        push_exp("d_r1", K_REG, 1, 8'h00);
        push_exp("d_r2", K_REG, 2, 8'h11);
        push_exp("d_pc", K_PC, 0, 8'h0A);
        push_exp("d_retired", K_RET, 0, 4);
        run_program("d", 300);

        // SUB R1,R2 (3-0) -> Z=0, BNE taken to 0x20
        clear_prog();
        put(8'h00, 8'h03, 8'h04);
        put(8'h02, 8'h00, 8'h46);
        put(8'h04, 8'h20, 8'h90);
        put(8'h06, 8'h11, 8'h08);
        put(8'h08, 8'h00, 8'hF0);
        put(8'h20, 8'h22, 8'h0C);
        put(8'h22, 8'h00, 8'hF0);
        push_exp("e_r2", K_REG, 2, 8'h00);
        push_exp("e_r3", K_REG, 3, 8'h22);
        push_exp("e_pc", K_PC, 0, 8'h24);
        push_exp("e_retired", K_RET, 0, 4);
        push_exp("e_lat_bne", K_LAT, 2, 3);
        run_program("e", 300);

        // Opcode 0xC is undefined: NOP plus Illegal pulse
        clear_prog();
        put(8'h00, 8'h00, 8'hC0);
        put(8'h02, 8'h05, 8'h04);
        put(8'h04, 8'h00, 8'hF0);
        push_exp("f_ill_cycles", K_ILL, 0, 1);
        push_exp("f_ill_enables", K_VIOL, 0, 0);
        push_exp("f_r1", K_REG, 1, 8'h05);
        push_exp("f_retired", K_RET, 0, 2);
        push_exp("f_lat_ill", K_LAT, 0, 3);
        run_program("f", 300);

        // HALT ignores Start
        for (int c = 0; c < 5; c++) @(negedge Clock);
        check("halt_sticky", int'(Halted), 1);
        check("halt_retired_frozen", int'(Retired), 2);

        // Reset during FETCH_H of the second instruction, then resume
        begin
            logic found;
            clear_prog();
            put(8'h00, 8'h03, 8'h04);
            put(8'h02, 8'h04, 8'h08);
            put(8'h04, 8'h00, 8'h36);
            put(8'h06, 8'h40, 8'h21);
            put(8'h08, 8'h00, 8'hF0);
            Reset_n = 1'b0; Start = 1'b0; load_req = 1'b1;
            @(posedge Clock);
            #1 load_req = 1'b0;
            @(negedge Clock);
            #1 Reset_n = 1'b1; Start = 1'b1;
            found = 1'b0;
            for (int c = 0; c < 50 && !found; c++) begin
                @(negedge Clock);
                if (Retired == 8'd1 && IR_Enable && IR_LH) found = 1'b1;
            end
            check("g_reached_fetch_h", int'(found), 1);
            Reset_n = 1'b0;
            #1;
            check("g_rst_ir_en", int'(IR_Enable), 0);
            check("g_rst_mem_cs", int'(Mem_CS), 1);
            check("g_rst_arf_rsel", int'(ARF_RSel), 0);
            check("g_rst_retired", int'(Retired), 0);
            @(negedge Clock);
            #1 Reset_n = 1'b1;
            @(negedge Clock);
            check("g_resume_init_rf", int'(RF_RSel), 4'hF);
            check("g_resume_init_arf", int'(ARF_RSel), 4'h3);
            for (int c = 0; c < 300 && !Halted; c++) @(negedge Clock);
            check("g_halted", int'(Halted), 1);
            check("g_retired", int'(Retired), 4);
            check("g_mem40", int'(mem[8'h40]), 8'h07);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_system_ctrl.md
Name: alu_system_ctrl

Overview:
- Hardwired control unit that sequences the ALU_System datapath (RF, ARF, IR, Memory, ALU, MUXA/B/C) through fetch, decode and execute.
- The program counter lives in the ARF. The controller reads only IR[15:8] and the ALU flags, and drives every ALU_System select and enable input.
- The controller sits beside ALU_System in the top level.

Parameters:
- RET_W, 8, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  level; leaves IDLE when high.
- IR_High  in  8  ALU_System out (IR[15:8]): opcode[7:4], Rd[3:2], Rs[1:0].
- ALU_ZCNO  in  4  registered ALU flags {Z,C,N,O}.
- MuxASel, MuxBSel  out  2 each;  MuxCSel  out  1.
- RF_OutASel, RF_OutBSel  out  3 each;  RF_FunSel  out  2;  RF_TSel, RF_RSel  out  4 each.
- ALU_FunSel  out  4.
- ARF_OutASel, ARF_OutBSel, ARF_FunSel  out  2 each;  ARF_RSel  out  4.
- IR_Funsel  out  2;  IR_Enable, IR_LH  out  1 each.
- Mem_WR, Mem_CS  out  1 each.
- Halted  out  1  high in HALT.
- Illegal  out  1  one-cycle pulse on an undefined opcode.
- Retired  out  RET_W  count of completed instructions; wraps.

Behaviour:
- Control outputs are combinational from state and IR_High. State, Retired and Illegal are registered.
- Idle output set (driven at reset and in every state unless overridden below):
  - RF_RSel = RF_TSel = ARF_RSel = 0; IR_Enable = 0; Mem_CS = 1; Mem_WR = 0.
  - All mux and OutSel fields = 0; FunSel fields = 0.
  - Halted = 0, Illegal = 0, Retired = 0.
- Reset_n low at any time forces IDLE and the idle outputs immediately, including mid-instruction. A partially fetched IR is discarded.
- Datapath conventions:
  - FunSel encodings: 00 clear, 01 load, 10 inc, 11 dec.
  - Rn (n = 0..3) maps to RF OutSel 3'b1nn and RSel 4'b1000>>n.
  - ARF: PC = 2'b11, AR = 2'b10; RSel PC = 4'b0001, AR = 4'b0010.
  - Memory read is combinational; write commits on the clock edge.
- States:
  - IDLE: outputs idle. Go to INIT when Start = 1.
  - INIT (1 cycle): ARF clear PC and AR; RF clear R1-R4 (RSel = 1111, FunSel = clear). Go to FETCH_L.
  - FETCH_L (T0): ARF_OutBSel = PC, Mem_CS = 0, IR_Enable = 1, IR_LH = 0, IR_Funsel = load, ARF inc PC. Go to FETCH_H.
  - FETCH_H (T1): same as FETCH_L with IR_LH = 1. IR_High is valid from the next cycle. Go to EXEC1.
  - EXEC1 (T2), per opcode:
    - 0 LDI: MuxASel = 2, RF load Rd. Done.
    - 1 LD: MuxBSel = 2, ARF load AR. Go to EXEC2.
    - 2 ST: MuxBSel = 2, ARF load AR. Go to EXEC2.
    - 3 ADD / 4 SUB / 5 AND / 6 OR: MuxCSel = 0, OutASel = Rd, OutBSel = Rs, ALU_FunSel = ADD/SUB/AND/OR, MuxASel = 0, RF load Rd. Done.
    - 7 INC: RF inc Rd. Done.
    - 8 BRA: MuxBSel = 2, ARF load PC. Done.
    - 9 BNE: if Z = 0, as BRA; else no write. Done.
    - F HLT: go to HALT.
    - Others: idle outputs, Illegal = 1 next cycle. Treated as done (NOP).
  - EXEC2 (T3):
    - LD: ARF_OutBSel = AR, Mem_CS = 0, MuxASel = 1, RF load Rd.
    - ST: ARF_OutBSel = AR, OutASel = Rs, MuxCSel = 0, ALU PASS_A, Mem_CS = 0, Mem_WR = 1.
    - Done.
  - "Done": Retired += 1 (mod 2^RET_W), next state FETCH_L.
  - HALT: idle outputs, Halted = 1. Only Reset_n exits. Start is ignored.
- Timing: ALU_ZCNO is sampled in EXEC1 and reflects the last ALU-writing instruction.
- Latency:
  - 3 cycles: LDI, ALU ops, INC, BRA, BNE, illegal.
  - 4 cycles: LD, ST.
- PC wraps 0xFF to 0x00 in the ARF; the controller takes no action on wrap.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - FunSel, ALU_FunSel (PASS_A, ADD, SUB, AND, OR) and MUX select constants;
  - ARF/RF select constants.
- Optional sub-module alu_ctrl_decode: combinational map from state and IR_High to the control-word outputs. The FSM and counters stay in the top module.

Test Plan:
- Reset then Start = 1; memory holds LDI R1,0x05 at 0x00-0x01 and HLT after → INIT clears PC, R1 = 0x05 after 3 execute cycles, Halted = 1, Retired = 1.
- LDI R1,3; LDI R2,4; ADD R1,R2; ST [0x40],R1 → mem[0x40] = 0x07; ST cycle shows Mem_WR = 1, Mem_CS = 0 for exactly 1 cycle; Retired = 4.
- LD R3,[0x40] with mem[0x40] = 0xA5 → R3 = 0xA5, 4-cycle latency.
- SUB R1,R1 (Z = 1) then BNE 0x20 → PC unchanged (next fetch at PC+2). With Z = 0 → next fetch address 0x20.
- Opcode 0xC → Illegal pulses 1 cycle, no RF/ARF/Mem enables, execution continues.
- Reset_n dropped during FETCH_H → outputs idle in the same cycle, state IDLE, Retired = 0. Hold Start to resume from INIT.
